// File: rtl/energy_pkg.sv
// Shared types and constants for the energy sample UART readout path.
package energy_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] FRAME_HEADER    = 8'hA5;
  localparam int         BYTES_PER_FRAME = 3;
  localparam int         BITS_PER_BYTE   = 8;

  // Checksum byte that closes every frame.
  function automatic logic [7:0] frame_checksum(input logic [7:0] hdr,
                                                input logic [7:0] smp);
    return hdr ^ smp;
  endfunction

endpackage

// File: rtl/energy_sample_fifo.sv
// Small synchronous sample FIFO with wrap-around pointers and an occupancy count.
module energy_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_en, pop_en;

  // Full/empty come straight from the registered count, so they reflect pre-edge state.
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem[rd_ptr_q];
  assign push_en  = push & ~full;
  assign pop_en   = pop & ~empty;

  // Pointer and count next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= push_data;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/energy_sample_uart_tx.sv
// Queues 8-bit samples and sends each as a 3-byte 8N1 frame: header, sample, header^sample.
module energy_sample_uart_tx
  import energy_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 104,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] HEADER       = FRAME_HEADER
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_valid,
  input  logic [7:0]                  sample_data,
  input  logic                        tx_enable,
  input  logic                        clr_overflow,
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(BITS_PER_BYTE - 1);
  localparam logic [1:0]    BYTE_LAST = 2'(BYTES_PER_FRAME - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    sample_q, sample_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;

  logic          pop;
  logic [7:0]    head_data;
  logic          fifo_empty;

  energy_sample_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (8)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (sample_valid),
    .push_data(sample_data),
    .pop      (pop),
    .pop_data (head_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Drops are judged on pre-edge fullness; a new drop beats a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (sample_valid && fifo_full) ovf_d = 1'b1;
    else if (clr_overflow)         ovf_d = 1'b0;
  end

  // Frame sequencer; tx_d is the line level for the cycle after the edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    sample_d   = sample_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_enable && !fifo_empty) begin
          pop        = 1'b1;
          sample_d   = head_data;
          shift_d    = HEADER;
          byte_idx_d = 2'd0;
          cnt_d      = '0;
          state_d    = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (byte_idx_q != BYTE_LAST) begin
            // Next byte follows straight on, no idle gap inside a frame.
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = (byte_idx_q == 2'd0) ? sample_q
                                              : frame_checksum(HEADER, sample_q);
            state_d    = START;
            tx_d       = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Sequencer and registered outputs; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      sample_q   <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      sample_q   <= sample_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_energy_sample_uart_tx.sv
// Bench for energy_sample_uart_tx: frame-level reference model plus scenario tasks.
module tb_energy_sample_uart_tx;

  localparam int C  = 4;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;
  localparam int FL = 30 * C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [7:0]    sample_data = 8'h00;
  logic          tx_enable = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          tx, busy, fifo_full, overflow;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;

  energy_sample_uart_tx #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D),
    .HEADER      (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .tx_enable   (tx_enable),
    .clr_overflow(clr_overflow),
    .tx          (tx),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of samples and a frame as 30 line bits, each C cycles long.
  logic [7:0]    m_q[$];
  logic          m_ovf = 1'b0;
  logic          m_act = 1'b0;
  int            m_k = 0;
  logic [29:0]   m_bits = '1;
  logic          e_tx = 1'b1, e_busy = 1'b0, e_full = 1'b0, e_ovf = 1'b0;
  logic [LW-1:0] e_lvl = '0;

  logic [LW+3:0] obs, expv;
  assign obs  = {tx, busy, fifo_full, fifo_level, overflow};
  assign expv = {e_tx, e_busy, e_full, e_lvl, e_ovf};

  function automatic logic [29:0] mk_frame(input logic [7:0] s);
    logic [7:0]  b [3];
    logic [29:0] f;
    b[0] = 8'hA5;
    b[1] = s;
    b[2] = 8'hA5 ^ s;
    f = '0;
    for (int i = 0; i < 3; i++) begin
      f[i*10] = 1'b0;
      for (int j = 0; j < 8; j++) f[i*10+1+j] = b[i][j];
      f[i*10+9] = 1'b1;
    end
    return f;
  endfunction

  task automatic model_step();
    logic full_pre;
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_act = 1'b0;
      m_k   = 0;
    end else begin
      full_pre = (m_q.size() == D);
      if (m_act) begin
        m_k++;
        if (m_k == FL) m_act = 1'b0;
      end else if (tx_enable && m_q.size() > 0) begin
        m_bits = mk_frame(m_q.pop_front());
        m_act  = 1'b1;
        m_k    = 0;
      end
      if (sample_valid && !full_pre) m_q.push_back(sample_data);
      if (sample_valid && full_pre) m_ovf = 1'b1;
      else if (clr_overflow)        m_ovf = 1'b0;
    end
    e_tx   = m_act ? m_bits[m_k / C] : 1'b1;
    e_busy = m_act;
    e_lvl  = LW'(m_q.size());
    e_full = (m_q.size() == D);
    e_ovf  = m_ovf;
  endtask

  // One clock: model sees the same pre-edge inputs as the DUT; outputs are read at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, {LW{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got %b want %b", obs, {1'b1, 1'b0, 1'b0, {LW{1'b0}}, 1'b0});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (obs !== {1'b1, 1'b0, 1'b0, {LW{1'b0}}, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got %b", i, obs);
      end
    end
  endtask

  task automatic test_single_frame();
    int busy_cnt = 0;
    tx_enable = 1'b1;
    push(8'h3C);
    for (int i = 0; i < FL + 10; i++) begin
      tick();
      if (busy) busy_cnt++;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL single_frame cyc=%0d got %b want %b", i, obs, expv);
      end
    end
    checks++;
    if (busy_cnt != FL || fifo_level !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_frame_len busy_cycles=%0d level=%0d want %0d/0", busy_cnt, fifo_level, FL);
    end
  endtask

  task automatic test_overflow();
    tx_enable = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i));
    checks++;
    if (fifo_level !== LW'(4) || fifo_full !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_fill level=%0d full=%b ovf=%b want 4/1/1", fifo_level, fifo_full, overflow);
    end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got %b want 0", overflow);
    end
    tx_enable = 1'b1;
    for (int i = 0; i < 4 * (FL + 1) + 10; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL drain_four cyc=%0d got %b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_full_pop_push();
    tx_enable = 1'b0;
    for (int i = 0; i < D; i++) push(8'($urandom));
    tx_enable    = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 8'($urandom);
    tick();
    sample_valid = 1'b0;
    checks++;
    if (fifo_level !== LW'(3) || overflow !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_push level=%0d ovf=%b busy=%b want 3/1/1", fifo_level, overflow, busy);
    end
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL full_pop_push_model got %b want %b", obs, expv);
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 40; i++) tick();
    tx_enable = 1'b0;
    for (int i = 0; i < FL + 30; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL enable_drop cyc=%0d got %b want %b", i, obs, expv);
      end
    end
    checks++;
    if (fifo_level !== LW'(3) || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL enable_drop_hold level=%0d busy=%b tx=%b want 3/0/1", fifo_level, busy, tx);
    end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    tx_enable = 1'b1;
    for (int i = 0; i < 3 * (FL + 1) + 10; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL enable_resume cyc=%0d got %b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    tx_enable = 1'b1;
    push(8'h5A);
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_mid_pre cyc=%0d got %b want %b", i, obs, expv);
      end
      if (m_act && m_k == 2 * C + 1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_wait got no DATA phase want DATA within 200 cycles");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async tx=%b busy=%b want 1/0", tx, busy);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tick();
      checks++;
      if (obs !== expv || tx !== 1'b1 || busy !== 1'b0 || fifo_level !== '0) begin
        errors++;
        $display("FAIL reset_mid_after cyc=%0d got %b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random cyc=%0d got %b want %b", i, obs, expv);
      end
      sample_valid = ($urandom_range(0, 29) == 0);
      sample_data  = 8'($urandom);
      clr_overflow = ($urandom_range(0, 49) == 0);
      if (i % 97 == 0) tx_enable = 1'($urandom_range(0, 1));
    end
    sample_valid = 1'b0;
    clr_overflow = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_full_pop_push();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/energy_sample_uart_tx.md
Name: energy_sample_uart_tx

Overview:
- Readout counterpart to the data collector: accepts converted 8-bit voltage samples, buffers them in a small FIFO, and serialises each one as a framed UART message on a single TX pin.
- Sits between the data collector output and a uo_out bit in the tt_um top level.
- An external logger reads the stream.
- Frame format: header byte 0xA5, sample byte, checksum byte (header XOR sample). Each byte is sent 8N1, LSB first.

Parameters:
- CLKS_PER_BIT, 104: clock cycles per UART bit; legal range is 2 or more.
- FIFO_DEPTH, 8: sample FIFO entries; must be a power of 2, 2 or more.
- HEADER, 8'hA5: frame header byte.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sample_valid  input  1  one-cycle strobe; sample_data is valid
- sample_data  input  8  converted voltage sample
- tx_enable  input  1  allows new frames to start
- clr_overflow  input  1  clears the overflow flag
- tx  output  1  UART serial out; idle level is 1
- busy  output  1  a frame is in progress
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count
- overflow  output  1  sticky flag: a sample was dropped

Behaviour:
- Clock and reset:
  - Single clock domain, clk. rst_n is asynchronous and active-low.
  - Reset values: tx=1, busy=0, fifo_full=0, fifo_level=0, overflow=0.
  - Reset also empties the FIFO and puts the FSM in IDLE.
- Reset mid-frame: tx returns to 1 immediately (asynchronously); the partial frame is abandoned and is not resumed.
- FIFO write:
  - sample_valid=1 and fifo_full=0 → push on that clk edge.
  - sample_valid=1 and fifo_full=1 → sample dropped, overflow set.
  - fullness is judged on the pre-edge state. A push is therefore dropped even when a pop happens in the same cycle.
- overflow:
  - Sticky; cleared by clr_overflow=1.
  - If a new drop and clr_overflow coincide, the set wins.
- fifo_level: a simultaneous push and pop leaves it unchanged. It never exceeds FIFO_DEPTH and never goes below 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0.
    - If tx_enable=1 and the FIFO is non-empty: pop the head, latch the sample, load shift register with HEADER, set byte_idx=0, go to START.
    - tx falls to 0 on the edge after the pop cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[bit_idx] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx<2: load the next byte (byte 1 = sample, byte 2 = HEADER^sample), increment byte_idx, go to START with no idle gap.
    - If byte_idx=2: go to IDLE.
- Frame timing: 30*CLKS_PER_BIT cycles with tx active.
  - Back-to-back frames have exactly one IDLE cycle between the last stop bit and the next start bit.
- tx_enable=0: no new frame starts. A frame in progress always completes. Samples continue to queue.
- busy=1 from the START entry edge through the final STOP cycle.
- Counters:
  - bit-time counter width is $clog2(CLKS_PER_BIT).
  - bit_idx is 3 bits; byte_idx is 2 bits.
  - No counter wraps beyond its terminal value.
- tx, busy and all status outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package (energy_pkg):
  - FSM state enum: IDLE, START, DATA, STOP.
  - FRAME_HEADER constant 8'hA5.
  - BYTES_PER_FRAME=3 and BITS_PER_BYTE=8.
- One sub-module: energy_sample_fifo, a synchronous FIFO with parameter DEPTH.
  - Ports: push, push_data, pop, pop_data, full, empty, level.
  - Wrap-around read/write pointers; level counter.
- The UART serialiser and frame sequencer stay in the top of this block.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset then idle for 50 cycles → tx=1, busy=0, fifo_level=0, overflow=0 throughout.
- Push 0x3C with tx_enable=1 → line carries bytes 0xA5, 0x3C, 0x99 LSB-first 8N1, 120 cycles total; busy falls after the last stop bit; fifo_level returns to 0.
- With tx_enable=0, push 5 samples 0x01..0x05 → fifo_level=4, fifo_full=1, overflow=1.
  - clr_overflow pulse → overflow=0.
  - Set tx_enable=1 → four frames for 0x01..0x04, with exactly 1 idle cycle between frames.
- With FIFO full and a frame starting (pop), push on the same cycle → push dropped, overflow=1, fifo_level=3 afterwards.
- Drop tx_enable mid-frame → current frame completes all 3 bytes; the next queued sample stays queued until tx_enable=1.
- Assert rst_n=0 during DATA of byte 1 → tx=1 within the same cycle (asynchronous); after release: busy=0, fifo_level=0, and no residual bits are sent.
